// File: rtl/fir_frame_seq.sv
// Frame sequencer for a free-running FIR core: streams one frame of samples,
// appends zero flush samples, and tags the FIR results with valid/last/done.
module fir_frame_seq #(
  parameter int DW_IN     = 8,
  parameter int DW_OUT    = 10,
  parameter int LATENCY   = 1,
  parameter int FLUSH_LEN = 4,
  parameter int LEN_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  frame_len,
  output logic              busy,
  output logic              done,
  output logic              underrun,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DW_IN-1:0]  s_data,
  output logic [DW_IN-1:0]  fir_in,
  input  logic [DW_OUT-1:0] fir_out,
  output logic              m_valid,
  output logic [DW_OUT-1:0] m_data,
  output logic              m_last,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DRAIN} state_t;

  localparam logic [LEN_W:0] ONE        = (LEN_W+1)'(1);
  localparam logic [LEN_W:0] FLUSH_W    = (LEN_W+1)'(FLUSH_LEN);
  localparam logic [LEN_W:0] FLUSH_LAST = FLUSH_W - ONE;

  state_t         state;
  logic [LEN_W:0] len_q;
  logic [LEN_W:0] slot_cnt;
  logic [LEN_W:0] out_cnt;
  logic [LEN_W:0] total;
  logic [LATENCY:0] tag_pipe;
  logic           slot;
  logic           beat;
  logic           last_beat;

  // tag_pipe[k] holds the tag of the sample loaded k edges ago.
  assign slot      = (state == RUN) || (state == FLUSH);
  assign total     = len_q + FLUSH_W;
  assign beat      = tag_pipe[LATENCY];
  assign last_beat = beat && (out_cnt == total - ONE);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fir_in   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      underrun <= 1'b0;
      s_ready  <= 1'b0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_last   <= 1'b0;
      len_q    <= '0;
      slot_cnt <= '0;
      out_cnt  <= '0;
      tag_pipe <= '0;
    end else begin
      done     <= 1'b0;
      m_last   <= 1'b0;
      m_valid  <= beat;
      tag_pipe <= {tag_pipe[LATENCY-1:0], slot};
      if (beat) begin
        m_data  <= fir_out;
        out_cnt <= out_cnt + ONE;
      end

      case (state)
        IDLE: begin
          fir_in <= '0;
          busy   <= 1'b0;
          if (start) begin
            if (frame_len != '0) begin
              len_q    <= {1'b0, frame_len};
              underrun <= 1'b0;
              slot_cnt <= '0;
              out_cnt  <= '0;
              s_ready  <= 1'b1;
              busy     <= 1'b1;
              state    <= RUN;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (s_valid && s_ready) begin
            fir_in <= s_data;
          end else begin
            fir_in   <= '0;
            underrun <= 1'b1;
          end
          slot_cnt <= slot_cnt + ONE;
          if (slot_cnt == len_q - ONE) begin
            slot_cnt <= '0;
            s_ready  <= 1'b0;
            state    <= (FLUSH_LEN == 0) ? DRAIN : FLUSH;
          end
        end
        FLUSH: begin
          fir_in   <= '0;
          slot_cnt <= slot_cnt + ONE;
          if (slot_cnt == FLUSH_LAST) begin
            slot_cnt <= '0;
            state    <= DRAIN;
          end
        end
        default: begin
          fir_in <= '0;
        end
      endcase

      // The final beat closes the frame; busy stays high through this cycle.
      if (last_beat) begin
        m_last  <= 1'b1;
        done    <= 1'b1;
        out_cnt <= '0;
        state   <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_fir_frame_seq.sv
// Randomized bench for fir_frame_seq with a 5-tap FIR core model and a
// scoreboard of expected result beats checked by an independent monitor.
module tb_fir_frame_seq;

  localparam int DW_IN = 8, DW_OUT = 10, LATENCY = 1, FLUSH_LEN = 4, LEN_W = 16;

  logic              clk;
  logic              rst;
  logic              start;
  logic [LEN_W-1:0]  frame_len;
  logic              busy, done, underrun;
  logic              s_valid, s_ready;
  logic [DW_IN-1:0]  s_data;
  logic [DW_IN-1:0]  fir_in;
  logic [DW_OUT-1:0] fir_out;
  logic              m_valid, m_last;
  logic [DW_OUT-1:0] m_data;
  logic [1:0]        state_dbg;

  int total = 0;
  int bad   = 0;
  logic [DW_OUT:0] exp_q[$];
  int  yq[$];
  bit  zero_done_ok = 0;

  fir_frame_seq #(
    .DW_IN(DW_IN), .DW_OUT(DW_OUT), .LATENCY(LATENCY),
    .FLUSH_LEN(FLUSH_LEN), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
    .busy(busy), .done(done), .underrun(underrun),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .fir_in(fir_in), .fir_out(fir_out),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIR core stand-in: out = 1*x[n] + 2*x[n-1] + ... + 5*x[n-4], one edge late.
  logic [DW_IN-1:0] h [0:3];
  always @(posedge clk) begin
    if (rst) begin
      fir_out <= '0;
      for (int i = 0; i < 4; i++) h[i] <= '0;
    end else begin
      fir_out <= DW_OUT'(32'(fir_in) + 2*32'(h[0]) + 3*32'(h[1]) + 4*32'(h[2]) + 5*32'(h[3]));
      h[0] <= fir_in;
      h[1] <= h[0];
      h[2] <= h[1];
      h[3] <= h[2];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_flags"}, {busy, done, underrun, s_ready, m_valid, m_last}, 0);
    chk({name, "_fir_in"}, fir_in, 0);
    chk({name, "_m_data"}, m_data, 0);
  endtask

  // Expected beat k of a frame: weighted window over the frame's sample stream.
  task automatic push_exp(input int k, input int tot);
    int acc;
    logic [DW_OUT:0] e;
    acc = 0;
    for (int j = 0; j < 5; j++)
      if (k - j >= 0) acc += (j + 1) * yq[k-j];
    e = {(k == tot - 1), acc[DW_OUT-1:0]};
    exp_q.push_back(e);
  endtask

  // scoreboard monitor
  logic [DW_OUT:0] mon_e;
  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_beat: got m_data=%0d with no expected beat", m_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("m_data", m_data, mon_e[DW_OUT-1:0]);
          chk("m_last", m_last, mon_e[DW_OUT]);
          chk("done_with_last", done, mon_e[DW_OUT]);
        end
      end else begin
        if (m_last) begin
          total++; bad++;
          $display("FAIL m_last_no_valid: got m_last=1 expected 0");
        end
        if (done && !zero_done_ok) begin
          total++; bad++;
          $display("FAIL stray_done: got done=1 expected 0");
        end
      end
    end
  end

  // driver: miss_mode 0 none, 1 one forced miss at miss_slot, 2 random misses;
  // fixed_data uses 10,20,30,...; start_slot/abort_slot < 0 disables them.
  task automatic run_frame(input int len, input int miss_mode, input int miss_slot,
                           input bit fixed_data, input int start_slot, input int abort_slot);
    int  tot, n;
    bit  any_miss, v;
    logic [DW_IN-1:0] d;
    tot = len + FLUSH_LEN;
    any_miss = 0;
    yq.delete();
    start = 1; frame_len = LEN_W'(len); s_valid = 0;
    @(posedge clk); #1;
    start = 0; frame_len = LEN_W'($urandom);
    chk("busy_after_start", busy, 1);
    chk("underrun_cleared", underrun, 0);
    for (int i = 0; i < len; i++) begin
      chk("s_ready_run", s_ready, 1);
      v = (miss_mode == 1) ? (i != miss_slot) :
          (miss_mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      d = fixed_data ? DW_IN'(10 * (i + 1)) : DW_IN'($urandom_range(1, 255));
      s_valid = v; s_data = d;
      if (!v) any_miss = 1;
      if (i == start_slot) begin start = 1; frame_len = 9; end
      if (i == abort_slot) rst = 1;
      yq.push_back(v ? int'(d) : 0);
      push_exp(i, tot);
      @(posedge clk); #1;
      start = 0;
      if (i == abort_slot) begin
        rst = 0; s_valid = 0;
        exp_q.delete();
        chk_all_zero("abort");
        repeat (8) @(posedge clk);
        #1;
        chk_all_zero("after_abort");
        return;
      end
      chk("fir_in_run", fir_in, v ? d : 0);
    end
    s_valid = 0;
    chk("s_ready_drop", s_ready, 0);
    for (int f = 0; f < FLUSH_LEN; f++) begin
      yq.push_back(0);
      push_exp(len + f, tot);
      @(posedge clk); #1;
      chk("fir_in_flush", fir_in, 0);
      chk("s_ready_flush", s_ready, 0);
    end
    chk("underrun_frame", underrun, any_miss);
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_seen", done, 1);
    chk("busy_in_done", busy, 1);
    @(posedge clk); #1;
    chk("busy_after_done", busy, 0);
    chk("done_pulse", done, 0);
    chk("underrun_hold", underrun, any_miss);
    chk("beats_all", exp_q.size(), 0);
    repeat (5) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; start = 0; frame_len = 0; s_valid = 0; s_data = 0;
    for (int c = 0; c < 2; c++) begin
      start = 1'($urandom); frame_len = LEN_W'($urandom);
      s_valid = 1'($urandom); s_data = DW_IN'($urandom);
      @(posedge clk); #1;
      chk_all_zero("reset");
    end
    rst = 0; start = 0; s_valid = 0;
    repeat (5) @(posedge clk);
    #1;
    chk_all_zero("post_reset");

    run_frame(3, 0, 0, 1, -1, -1);   // nominal 10,20,30
    run_frame(4, 1, 1, 0, -1, -1);   // one empty slot
    run_frame(2, 0, 0, 0, -1, -1);   // clears underrun

    // zero-length frame
    start = 1; frame_len = 0; zero_done_ok = 1;
    @(posedge clk); #1;
    start = 0;
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_s_ready", s_ready, 0);
    @(posedge clk); #1;
    zero_done_ok = 0;
    chk("zero_done_pulse", done, 0);
    chk("zero_busy_after", busy, 0);
    repeat (3) @(posedge clk);
    #1;

    run_frame(5, 0, 0, 0, 2, -1);    // start while busy is ignored
    run_frame(6, 0, 0, 0, -1, 2);    // reset mid-RUN
    run_frame(2, 0, 0, 0, -1, -1);
    run_frame(1, 0, 0, 0, -1, -1);

    for (int r = 0; r < 6; r++)
      run_frame($urandom_range(1, 12), 2, 0, 0, -1, -1);

    repeat (10) @(posedge clk);
    #1;
    chk("queue_empty_end", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
